// File: rtl/mat_operand_fetch_pkg.sv
// +-------------------------------------------------------------------+
// | mat_operand_fetch_pkg : shared types/helpers for operand fetch    |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
`default_nettype none

package mat_operand_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fetch_state_t;

  function automatic int elems_of(input int n);
    return n * n;
  endfunction

  // Source element offset for B lane l = (r,c); transposed reads element (c,r).
  function automatic int b_lane_src(input int n, input int l, input logic trans);
    return trans ? ((l % n) * n + (l / n)) : l;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mat_fetch_fifo2.sv
// +-------------------------------------------------------------------+
// | mat_fetch_fifo2 : 2-entry FIFO, head visible on o_data            |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
`default_nettype none

module mat_fetch_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_valid,
  output logic [1:0]   o_occ
);

  logic [W-1:0] r_mem [2];
  logic         r_wp;
  logic         r_rp;
  logic [1:0]   r_occ;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wp     <= 1'b0;
      r_rp     <= 1'b0;
      r_occ    <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wp] <= i_data;
        r_wp        <= ~r_wp;
      end
      if (i_pop) r_rp <= ~r_rp;
      r_occ <= r_occ + {1'b0, i_push} - {1'b0, i_pop};
    end
  end

  assign o_data  = r_mem[r_rp];
  assign o_valid = (r_occ != 2'd0);
  assign o_occ   = r_occ;

endmodule

`default_nettype wire

// File: rtl/mat_operand_fetch.sv
// +-------------------------------------------------------------------+
// | mat_operand_fetch : streams NUM NxN A/B matrix pairs to multiplier |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
`default_nettype none

module mat_operand_fetch
  import mat_operand_fetch_pkg::*;
#(
  parameter int N  = 2,
  parameter int DW = 8,
  parameter int AW = 8,
  parameter int CW = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  input  logic [AW-1:0]       i_base_a,
  input  logic [AW-1:0]       i_base_b,
  input  logic [CW-1:0]       i_num,
  input  logic                i_trans_b,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_rd_en,
  output logic [N*N*AW-1:0]   o_rd_addr_a,
  output logic [N*N*AW-1:0]   o_rd_addr_b,
  input  logic [N*N*DW-1:0]   i_rd_data_a,
  input  logic [N*N*DW-1:0]   i_rd_data_b,
  output logic                o_out_valid,
  input  logic                i_out_ready,
  output logic [N*N*DW-1:0]   o_out_a,
  output logic [N*N*DW-1:0]   o_out_b,
  output logic                o_out_last
);

  localparam int ELEMS = elems_of(N);
  localparam int LW    = ELEMS * DW;
  localparam int FW    = 2 * LW + 1;

  fetch_state_t  r_state;
  logic [CW-1:0] r_beat;
  logic [CW-1:0] r_num;
  logic [AW-1:0] r_base_a;
  logic [AW-1:0] r_base_b;
  logic          r_trans;
  logic          r_rd_q;
  logic          r_last_q;

  logic [FW-1:0] w_head;
  logic          w_valid;
  logic [1:0]    w_occ;
  logic          w_pop;
  logic [2:0]    w_pend;
  logic          w_fetch;
  logic          w_last_beat;
  logic [AW-1:0] w_beat_ofs;

  assign w_pop       = w_valid & i_out_ready;
  // Entries that will occupy the buffer after this cycle if nothing new is issued.
  assign w_pend      = {1'b0, w_occ} + {2'b00, r_rd_q} - {2'b00, w_pop};
  assign w_fetch     = (r_state == ST_FETCH);
  assign w_last_beat = (r_beat == r_num - CW'(1));
  assign w_beat_ofs  = AW'(r_beat) * AW'(ELEMS);

  assign o_rd_en = w_fetch && (w_pend < 3'd2);
  assign o_busy  = (r_state == ST_FETCH) || (r_state == ST_DRAIN);
  assign o_done  = (r_state == ST_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_beat   <= '0;
      r_num    <= '0;
      r_base_a <= '0;
      r_base_b <= '0;
      r_trans  <= 1'b0;
      r_rd_q   <= 1'b0;
      r_last_q <= 1'b0;
    end else begin
      r_rd_q   <= o_rd_en;
      r_last_q <= o_rd_en && w_last_beat;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_base_a <= i_base_a;
            r_base_b <= i_base_b;
            r_num    <= i_num;
            r_trans  <= i_trans_b;
            r_beat   <= '0;
            r_state  <= (i_num == '0) ? ST_DONE : ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (o_rd_en) begin
            r_beat <= r_beat + CW'(1);
            if (w_last_beat) r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_pend == 3'd0) r_state <= ST_DONE;
        end
        ST_DONE:  r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  for (genvar l = 0; l < ELEMS; l++) begin : g_lane
    localparam int c_b_trans = b_lane_src(N, l, 1'b1);
    assign o_rd_addr_a[l*AW +: AW] = w_fetch ? (r_base_a + w_beat_ofs + AW'(l)) : '0;
    assign o_rd_addr_b[l*AW +: AW] = w_fetch ?
        (r_base_b + w_beat_ofs + (r_trans ? AW'(c_b_trans) : AW'(l))) : '0;
  end

  mat_fetch_fifo2 #(
    .W (FW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_rd_q),
    .i_data  ({r_last_q, i_rd_data_a, i_rd_data_b}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_valid (w_valid),
    .o_occ   (w_occ)
  );

  assign o_out_valid = w_valid;
  assign o_out_a     = w_head[LW +: LW];
  assign o_out_b     = w_head[0 +: LW];
  assign o_out_last  = w_valid & w_head[FW-1];

endmodule

`default_nettype wire

// File: tb/tb_mat_operand_fetch.sv
// +-------------------------------------------------------------------+
// | tb_mat_operand_fetch : random + directed bench with pair model     |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
`default_nettype none

module tb_mat_operand_fetch;

  localparam int N  = 2;
  localparam int EL = N * N;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start;
  logic [7:0]  i_base_a, i_base_b, i_num;
  logic        i_trans_b;
  logic        o_busy, o_done, o_rd_en;
  logic [31:0] o_rd_addr_a, o_rd_addr_b;
  logic [31:0] rd_data_a, rd_data_b;
  logic        o_out_valid, i_out_ready;
  logic [31:0] o_out_a, o_out_b;
  logic        o_out_last;

  logic [7:0]  mem_a [256];
  logic [7:0]  mem_b [256];
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  mat_operand_fetch #(.N(N), .DW(8), .AW(8), .CW(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_start     (i_start),
    .i_base_a    (i_base_a),
    .i_base_b    (i_base_b),
    .i_num       (i_num),
    .i_trans_b   (i_trans_b),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_rd_en     (o_rd_en),
    .o_rd_addr_a (o_rd_addr_a),
    .o_rd_addr_b (o_rd_addr_b),
    .i_rd_data_a (rd_data_a),
    .i_rd_data_b (rd_data_b),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_out_a     (o_out_a),
    .o_out_b     (o_out_b),
    .o_out_last  (o_out_last)
  );

  // Synchronous-read operand memories, one cycle of latency.
  always @(posedge clk) begin
    if (o_rd_en) begin
      for (int l = 0; l < EL; l++) begin
        rd_data_a[l*8 +: 8] <= mem_a[o_rd_addr_a[l*8 +: 8]];
        rd_data_b[l*8 +: 8] <= mem_b[o_rd_addr_b[l*8 +: 8]];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int b_src(input int l, input logic tr);
    int r, c;
    r = l / N;
    c = l % N;
    return tr ? (c * N + r) : l;
  endfunction

  // mode 0: ready always high; 1: ready low cycles 3..6; 2: random ready
  task automatic run_cmd(input logic [7:0] ba, input logic [7:0] bb, input logic [7:0] cnt,
                         input logic tr, input int mode, input bit poke);
    logic [31:0] qa[$];
    logic [31:0] qb[$];
    logic        ql[$];
    logic [31:0] ea, eb, hold_a, hold_b;
    logic [7:0]  ad;
    int          issued, done_cyc, first_v, last_pop;
    bit          holding;
    for (int i = 0; i < int'(cnt); i++) begin
      for (int l = 0; l < EL; l++) begin
        ad = ba + 8'(i * EL + l);
        ea[l*8 +: 8] = mem_a[ad];
        ad = bb + 8'(i * EL + b_src(l, tr));
        eb[l*8 +: 8] = mem_b[ad];
      end
      qa.push_back(ea);
      qb.push_back(eb);
      ql.push_back(i == int'(cnt) - 1);
    end
    issued = 0; done_cyc = -1; first_v = -1; last_pop = -1; holding = 0;
    @(negedge clk);
    i_start = 1'b1; i_base_a = ba; i_base_b = bb; i_num = cnt; i_trans_b = tr;
    i_out_ready = 1'b1;
    for (int k = 1; k <= 300 && done_cyc < 0; k++) begin
      @(negedge clk);
      i_base_a  = 8'($urandom);
      i_base_b  = 8'($urandom);
      i_num     = 8'($urandom_range(1, 9));
      i_trans_b = 1'($urandom);
      i_start   = poke && (k == 2);
      case (mode)
        1:       i_out_ready = !(k >= 3 && k <= 6);
        2:       i_out_ready = ($urandom_range(0, 3) != 0);
        default: i_out_ready = 1'b1;
      endcase
      #1;
      if (o_rd_en) begin
        for (int l = 0; l < EL; l++) begin
          check("rd_addr_a", 32'(o_rd_addr_a[l*8 +: 8]), 32'(8'(ba + 8'(issued * EL + l))));
          check("rd_addr_b", 32'(o_rd_addr_b[l*8 +: 8]),
                32'(8'(bb + 8'(issued * EL + b_src(l, tr)))));
        end
        issued++;
      end
      if (o_out_valid && first_v < 0) first_v = k;
      if (holding) begin
        check("hold_a", o_out_a, hold_a);
        check("hold_b", o_out_b, hold_b);
        holding = 0;
      end
      if (o_out_valid) begin
        if (i_out_ready) begin
          if (qa.size() == 0) begin
            check("extra_pair", 32'd1, 32'd0);
          end else begin
            check("out_a", o_out_a, qa.pop_front());
            check("out_b", o_out_b, qb.pop_front());
            check("out_last", 32'(o_out_last), 32'(ql.pop_front()));
            last_pop = k;
          end
        end else begin
          holding = 1; hold_a = o_out_a; hold_b = o_out_b;
        end
      end
      if (o_done) begin
        done_cyc = k;
        check("busy_at_done", 32'(o_busy), 32'd0);
      end
    end
    i_start = 1'b0;
    if (done_cyc < 0) check("done_timeout", 32'd0, 32'd1);
    check("rd_count", 32'(issued), 32'(cnt));
    check("pairs_left", 32'(qa.size()), 32'd0);
    if (cnt == 8'd0) check("done_cyc_num0", 32'(done_cyc), 32'd1);
    else check("done_after_pop", 32'(done_cyc), 32'(last_pop + 1));
    if (mode == 0 && cnt != 8'd0) begin
      check("first_valid", 32'(first_v), 32'd3);
      check("done_cyc", 32'(done_cyc), 32'(3 + int'(cnt)));
    end
    if (mode == 1 && cnt != 8'd0) check("done_stalled", 32'(done_cyc), 32'(7 + int'(cnt)));
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},  32'(o_busy), 32'd0);
    check({tag, "_done"},  32'(o_done), 32'd0);
    check({tag, "_rd_en"}, 32'(o_rd_en), 32'd0);
    check({tag, "_addr"},  o_rd_addr_a | o_rd_addr_b, 32'd0);
    check({tag, "_valid"}, 32'(o_out_valid), 32'd0);
    check({tag, "_last"},  32'(o_out_last), 32'd0);
    check({tag, "_out"},   o_out_a | o_out_b, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 8'($urandom);
      mem_b[i] = 8'($urandom);
    end
    rst = 1'b1; i_start = 1'b0; i_base_a = '0; i_base_b = '0; i_num = '0;
    i_trans_b = 1'b0; i_out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b0;

    run_cmd(8'h00, 8'h40, 8'd3, 1'b0, 0, 0);
    run_cmd(8'h00, 8'h40, 8'd3, 1'b1, 0, 0);
    run_cmd(8'h10, 8'h80, 8'd4, 1'b0, 1, 0);
    run_cmd(8'hFE, 8'hFF, 8'd1, 1'b1, 0, 0);
    run_cmd(8'h20, 8'h30, 8'd0, 1'b0, 0, 0);
    run_cmd(8'h33, 8'h77, 8'd4, 1'b0, 0, 1);

    // Reset mid-run: rst sampled at the end of cycle 4 of a num=5 command.
    @(negedge clk);
    i_start = 1'b1; i_base_a = 8'h50; i_base_b = 8'h60; i_num = 8'd5; i_out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      i_start = 1'b0;
      if (k == 4) rst = 1'b1;
    end
    @(negedge clk);
    #1;
    check_idle_outputs("midrst");
    rst = 1'b0;
    run_cmd(8'h50, 8'h60, 8'd5, 1'b0, 0, 0);

    for (int t = 0; t < 25; t++) begin
      run_cmd(8'($urandom), 8'($urandom), 8'($urandom_range(0, 7)), 1'($urandom),
              ($urandom_range(0, 2) == 0) ? 0 : 2, ($urandom_range(0, 4) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mat_operand_fetch.md
# mat_operand_fetch

Parametrised operand fetch sequencer for the pipelined matrix multiplier. On a start command it streams NUM consecutive N×N matrix pairs from two synchronous-read operand memories (A and B). It generates all N*N element addresses per matrix per beat and can optionally transpose B. Fetched pairs go to the multiply pipeline over a valid/ready handshake with backpressure. It supersedes the fixed 2×2, free-running address counters.

## Interface
- N, 2: matrix dimension (2..4); ELEMS = N*N lanes
- DW, 8: element data width
- AW, 8: memory address width
- CW, 8: matrix-count width
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  command pulse; ignored while busy
- base_a, base_b  in  AW  first element address of matrix 0 in A / B memory
- num  in  CW  number of matrix pairs to fetch
- trans_b  in  1  1 = deliver B transposed; latched with start
- busy  out  1  command in progress
- done  out  1  one-cycle pulse after last pair handed off
- rd_en  out  1  read strobe to both memories
- rd_addr_a, rd_addr_b  out  ELEMS*AW  lane l address at [l*AW +: AW]
- rd_data_a, rd_data_b  in  ELEMS*DW  valid the cycle after rd_en (1-cycle read latency)
- out_valid  out  1  pair available
- out_ready  in  1  consumer accepts
- out_a, out_b  out  ELEMS*DW  lane l = element (r,c), l = r*N+c
- out_last  out  1  qualifies the final pair of the command

## Operation
- FSM: IDLE -> FETCH on start (num>0); IDLE -> DONE on start with num=0 (no reads); FETCH -> DRAIN after beat num-1 issued; DRAIN -> DONE when buffer empty and nothing in flight; DONE -> IDLE unconditionally (done=1 in DONE only).
- Start latches base_a, base_b, num, trans_b; inputs may change afterwards.
- Beat i addresses: A lane l = base_a + i*ELEMS + l. B lane l=(r,c) = base_b + i*ELEMS + (trans_b ? c*N+r : l). All sums modulo 2^AW (wrap silently).
- Output buffer: 2-entry FIFO of {a,b,last}, written the cycle after each rd_en with rd_data. out_* driven from the FIFO head; out_last = 1 for beat num-1.
- Issue rule: rd_en = (state==FETCH) && (occ + inflight - pop < 2), where pop = out_valid && out_ready. This gives a combinational path from out_ready to rd_en, accepted. The FIFO never overflows.
- out_a/out_b/out_last hold stable while out_valid && !out_ready.
- busy = (state != IDLE) && (state != DONE).

## Timing
- Reset values: busy=0, done=0, rd_en=0, rd_addrs=0, out_valid=0, out_last=0, out_a/out_b=0; FIFO empty, state IDLE.
- start sampled in cycle 0. Beat i issued cycle 1+i (no stalls). First out_valid cycle 3. Beat i presented cycle 3+i with out_ready held high. Last pop cycle 2+num. done in cycle 3+num. busy high cycles 1..2+num.
- Throughput: one pair per cycle sustained with out_ready=1.
- Stall: out_ready low for k cycles delays every later pair by k cycles; at most 2 beats buffered.
- start in DONE cycle is ignored; the earliest accepted restart is the cycle after done.
- rst mid-operation: next cycle all outputs at reset values, FIFO flushed. In-flight read data the cycle after rst is discarded.

## Structure
- Shared package: FSM state encoding (IDLE, FETCH, DRAIN, DONE), ELEMS derivation, lane slice helper.
- One sub-module: mat_fetch_fifo2, a 2-entry FIFO (parametrised width, push/pop/occ), reusable by the writeback stage.
- Address generator (beat counter, lane/transposed offset) stays in the top module.

## Test plan
- N=2, base_a=0x00, base_b=0x40, num=3, out_ready=1 -> rd_addr_a beats {0,1,2,3},{4,5,6,7},{8,9,10,11}; out_valid cycles 3..5; out_last on 3rd; done cycle 6.
- Same with trans_b=1 -> B lanes beat 0 = {0x40,0x42,0x41,0x43}; out_b lanes hold memory[0x40,0x42,0x41,0x43].
- num=4, out_ready low cycles 3..6 -> rd_en drops after 2 outstanding, no pair lost or duplicated, out_a stable while stalled; done 4 cycles later than unstalled.
- base_a=0xFE, N=2, num=1 -> lane addresses {0xFE,0xFF,0x00,0x01}.
- num=0 -> no rd_en, done pulse cycle 1; start while busy -> ignored, count unchanged.
- rst asserted in cycle 4 of a num=5 run -> cycle 5 all outputs zero, state IDLE; new start then runs cleanly from beat 0.
